// File: rtl/pch_bmc_pwr_seq.sv
// PCH AUX rail and PCH/BMC reset / power-good sequencer.
// Enables AUX, waits for SLP_S3#, then releases RSMRST#, SRST#, PCH_PWROK and SYS_PWROK in order.
module pch_bmc_pwr_seq #(
    parameter int T_AUX_TMO      = 2000,
    parameter int T_RSMRST_DLY   = 20,
    parameter int T_SRST_DLY     = 1,
    parameter int T_PCHPWROK_DLY = 1,
    parameter int T_SYSPWROK_DLY = 1,
    parameter int CNT_W          = 16
) (
    input  logic       iClk_2M,
    input  logic       iRst,
    input  logic       iSeqEn,
    input  logic       iPwrgdP1v8PchAux,
    input  logic       iSlpS3_n,
    output logic       oFmPchP1v8AuxEn,
    output logic       oRstRsmrstReq,
    output logic       oRstSrstBmcReq,
    output logic       oPwrgdPchPwrok,
    output logic       oPwrgdSysPwrok,
    output logic       oFault,
    output logic [1:0] oFaultCode,
    output logic [3:0] oState
);

    typedef enum logic [3:0] {
        IDLE      = 4'd0,
        AUX_WAIT  = 4'd1,
        S3_WAIT   = 4'd2,
        RSM_DLY   = 4'd3,
        SRST_DLY  = 4'd4,
        PCHOK_DLY = 4'd5,
        SYSOK_DLY = 4'd6,
        ON        = 4'd7,
        FAULT     = 4'd8
    } state_t;

    typedef enum logic [1:0] {
        FC_NONE     = 2'd0,
        FC_AUX_TMO  = 2'd1,
        FC_AUX_LOST = 2'd2
    } fault_code_t;

    typedef struct packed {
        logic aux_en;
        logic rsmrst_req;
        logic srst_req;
        logic pch_pwrok;
        logic sys_pwrok;
    } rails_t;

    // A timed state exits on the cycle its counter reaches N-1, so the output lands N cycles after entry.
    localparam logic [CNT_W-1:0] CNT_MAX    = '1;
    localparam logic [CNT_W-1:0] AUX_LAST   = CNT_W'(T_AUX_TMO - 1);
    localparam logic [CNT_W-1:0] RSM_LAST   = CNT_W'(T_RSMRST_DLY - 1);
    localparam logic [CNT_W-1:0] SRST_LAST  = CNT_W'(T_SRST_DLY - 1);
    localparam logic [CNT_W-1:0] PCHOK_LAST = CNT_W'(T_PCHPWROK_DLY - 1);
    localparam logic [CNT_W-1:0] SYSOK_LAST = CNT_W'(T_SYSPWROK_DLY - 1);

    state_t           state_q, state_d;
    logic [CNT_W-1:0] cnt_q;
    rails_t           rails_q, rails_d;
    logic             fault_q, fault_d;
    fault_code_t      code_q, code_d;

    logic [CNT_W-1:0] dly_last;
    state_t           dly_next;
    rails_t           dly_set;

    // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge iClk_2M or posedge iRst) begin
        if (iRst) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            rails_q <= '0;
            fault_q <= 1'b0;
            code_q  <= FC_NONE;
        end else begin
            state_q <= state_d;
            rails_q <= rails_d;
            fault_q <= fault_d;
            code_q  <= code_d;
            if (state_d != state_q) begin
                cnt_q <= '0;
            end else if (cnt_q != CNT_MAX) begin
                cnt_q <= cnt_q + 1'b1;
            end
        end
    end

    // Per-stage delay, successor and released output for the release chain.
    always_comb begin
        // NOTE: every combinational output gets a default first so no path can infer a latch.
        dly_last = RSM_LAST;
        dly_next = SRST_DLY;
        dly_set  = '0;
        case (state_q)
            RSM_DLY: begin
                dly_last           = RSM_LAST;
                dly_next           = SRST_DLY;
                dly_set.rsmrst_req = 1'b1;
            end
            SRST_DLY: begin
                dly_last         = SRST_LAST;
                dly_next         = PCHOK_DLY;
                dly_set.srst_req = 1'b1;
            end
            PCHOK_DLY: begin
                dly_last          = PCHOK_LAST;
                dly_next          = SYSOK_DLY;
                dly_set.pch_pwrok = 1'b1;
            end
            SYSOK_DLY: begin
                dly_last          = SYSOK_LAST;
                dly_next          = ON;
                dly_set.sys_pwrok = 1'b1;
            end
            default: ;
        endcase
    end

    always_comb begin
        state_d = state_q;
        rails_d = rails_q;
        fault_d = fault_q;
        code_d  = code_q;
        case (state_q)
            IDLE: begin
                rails_d = '0;
                if (iSeqEn) begin
                    state_d        = AUX_WAIT;
                    rails_d.aux_en = 1'b1;
                end
            end
            AUX_WAIT: begin
                if (!iSeqEn) begin
                    state_d = IDLE;
                    rails_d = '0;
                end else if (iPwrgdP1v8PchAux) begin
                    state_d = S3_WAIT;
                end else if (cnt_q == AUX_LAST) begin
                    state_d = FAULT;
                    rails_d = '0;
                    fault_d = 1'b1;
                    code_d  = FC_AUX_TMO;
                end
            end
            S3_WAIT: begin
                if (!iPwrgdP1v8PchAux) begin
                    state_d = FAULT;
                    rails_d = '0;
                    fault_d = 1'b1;
                    code_d  = FC_AUX_LOST;
                end else if (!iSeqEn) begin
                    state_d = IDLE;
                    rails_d = '0;
                end else if (iSlpS3_n) begin
                    state_d = RSM_DLY;
                end
            end
            RSM_DLY, SRST_DLY, PCHOK_DLY, SYSOK_DLY, ON: begin
                if (!iPwrgdP1v8PchAux) begin
                    state_d = FAULT;
                    rails_d = '0;
                    fault_d = 1'b1;
                    code_d  = FC_AUX_LOST;
                end else if (!iSeqEn) begin
                    state_d = IDLE;
                    rails_d = '0;
                end else if (!iSlpS3_n) begin
                    // S3 entry keeps AUX and the reset requests; only the power-goods drop.
                    state_d           = S3_WAIT;
                    rails_d.pch_pwrok = 1'b0;
                    rails_d.sys_pwrok = 1'b0;
                end else if (state_q != ON && cnt_q == dly_last) begin
                    state_d = dly_next;
                    rails_d = rails_q | dly_set;
                end
            end
            FAULT: begin
                rails_d = '0;
                if (!iSeqEn) begin
                    state_d = IDLE;
                    fault_d = 1'b0;
                    code_d  = FC_NONE;
                end
            end
            default: begin
                state_d = IDLE;
                rails_d = '0;
                fault_d = 1'b0;
                code_d  = FC_NONE;
            end
        endcase
    end

    assign oFmPchP1v8AuxEn = rails_q.aux_en;
    assign oRstRsmrstReq   = rails_q.rsmrst_req;
    assign oRstSrstBmcReq  = rails_q.srst_req;
    assign oPwrgdPchPwrok  = rails_q.pch_pwrok;
    assign oPwrgdSysPwrok  = rails_q.sys_pwrok;
    assign oFault          = fault_q;
    assign oFaultCode      = code_q;
    assign oState          = state_q;

endmodule

// File: tb/tb_pch_bmc_pwr_seq.sv
// Scoreboard bench for pch_bmc_pwr_seq: directed test-plan scenarios then random stimulus,
// checked against a phase/elapsed-time reference model.
module tb_pch_bmc_pwr_seq;

    localparam int T_AUX  = 2000;
    localparam int T_RSM  = 20;
    localparam int T_SRST = 1;
    localparam int T_PCH  = 1;
    localparam int T_SYS  = 1;
    // Cumulative release times measured from entry into the release chain.
    localparam int C_RSM  = T_RSM;
    localparam int C_SRST = C_RSM + T_SRST;
    localparam int C_PCH  = C_SRST + T_PCH;
    localparam int C_SYS  = C_PCH + T_SYS;

    logic       clk    = 1'b0;
    logic       rst    = 1'b1;
    logic       seq_en = 1'b0;
    logic       pg     = 1'b0;
    logic       slp_n  = 1'b0;
    logic       aux_en, rsm_req, srst_req, pch_pwrok, sys_pwrok, fault;
    logic [1:0] fault_code;
    logic [3:0] state;

    pch_bmc_pwr_seq #(
        .T_AUX_TMO      (T_AUX),
        .T_RSMRST_DLY   (T_RSM),
        .T_SRST_DLY     (T_SRST),
        .T_PCHPWROK_DLY (T_PCH),
        .T_SYSPWROK_DLY (T_SYS),
        .CNT_W          (16)
    ) dut (
        .iClk_2M          (clk),
        .iRst             (rst),
        .iSeqEn           (seq_en),
        .iPwrgdP1v8PchAux (pg),
        .iSlpS3_n         (slp_n),
        .oFmPchP1v8AuxEn  (aux_en),
        .oRstRsmrstReq    (rsm_req),
        .oRstSrstBmcReq   (srst_req),
        .oPwrgdPchPwrok   (pch_pwrok),
        .oPwrgdSysPwrok   (sys_pwrok),
        .oFault           (fault),
        .oFaultCode       (fault_code),
        .oState           (state)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic       aux, rsm, srst, pch, sys, flt;
        logic [1:0] code;
        logic [3:0] st;
    } obs_t;

    typedef enum {P_OFF, P_AUX, P_S3, P_CHAIN, P_FAULT} phase_t;

    phase_t     ph;
    int         t;
    bit         held_rsm, held_srst;
    logic [1:0] fcode;
    obs_t       exp_q[$];
    int         vectors     = 0;
    int         miscompares = 0;

    // Reference model: which phase the sequencer is in and how long it has been there.
    function automatic obs_t model_out();
        obs_t o = '0;
        case (ph)
            P_OFF: o.st = 4'd0;
            P_AUX: begin
                o.aux = 1'b1;
                o.st  = 4'd1;
            end
            P_S3: begin
                o.aux  = 1'b1;
                o.rsm  = held_rsm;
                o.srst = held_srst;
                o.st   = 4'd2;
            end
            P_CHAIN: begin
                o.aux  = 1'b1;
                o.rsm  = held_rsm || (t >= C_RSM);
                o.srst = held_srst || (t >= C_SRST);
                o.pch  = (t >= C_PCH);
                o.sys  = (t >= C_SYS);
                o.st   = 4'(3 + (t >= C_RSM) + (t >= C_SRST) + (t >= C_PCH) + (t >= C_SYS));
            end
            P_FAULT: begin
                o.flt  = 1'b1;
                o.code = fcode;
                o.st   = 4'd8;
            end
            default: o = '0;
        endcase
        return o;
    endfunction

    task automatic model_reset();
        ph        = P_OFF;
        t         = 0;
        held_rsm  = 1'b0;
        held_srst = 1'b0;
        fcode     = 2'd0;
    endtask

    task automatic enter(input phase_t p);
        ph = p;
        t  = 0;
    endtask

    task automatic model_fault(input logic [1:0] c);
        model_reset();
        ph    = P_FAULT;
        fcode = c;
    endtask

    task automatic model_step(input bit s, input bit p, input bit slp);
        obs_t now = model_out();
        case (ph)
            P_OFF:   if (s) enter(P_AUX);
            P_AUX: begin
                if (!s)              model_reset();
                else if (p)          enter(P_S3);
                else if (t + 1 >= T_AUX) model_fault(2'd1);
                else                 t++;
            end
            P_S3: begin
                if (!p)       model_fault(2'd2);
                else if (!s)  model_reset();
                else if (slp) enter(P_CHAIN);
            end
            P_CHAIN: begin
                if (!p)       model_fault(2'd2);
                else if (!s)  model_reset();
                else if (!slp) begin
                    held_rsm  = now.rsm;
                    held_srst = now.srst;
                    enter(P_S3);
                end else      t++;
            end
            P_FAULT: if (!s) model_reset();
            default: model_reset();
        endcase
    endtask

    function automatic obs_t dut_obs();
        obs_t o;
        o.aux  = aux_en;
        o.rsm  = rsm_req;
        o.srst = srst_req;
        o.pch  = pch_pwrok;
        o.sys  = sys_pwrok;
        o.flt  = fault;
        o.code = fault_code;
        o.st   = state;
        return o;
    endfunction

    task automatic check(input string name, input obs_t got, input obs_t exp);
        vectors++;
        if (got !== exp) begin
            miscompares++;
            $display("FAIL %s at %0t: got aux/rsm/srst/pch/sys/flt=%b%b%b%b%b%b code=%0d state=%0d, expected %b%b%b%b%b%b code=%0d state=%0d",
                     name, $time, got.aux, got.rsm, got.srst, got.pch, got.sys, got.flt, got.code, got.st,
                     exp.aux, exp.rsm, exp.srst, exp.pch, exp.sys, exp.flt, exp.code, exp.st);
        end
    endtask

    // Drive one set of inputs for the coming edge and queue the response the model predicts.
    task automatic cycle(input bit r, input bit s, input bit p, input bit slp);
        @(negedge clk);
        rst    = r;
        seq_en = s;
        pg     = p;
        slp_n  = slp;
        if (r) model_reset();
        else   model_step(s, p, slp);
        exp_q.push_back(model_out());
    endtask

    task automatic run(input int n, input bit s, input bit p, input bit slp);
        repeat (n) cycle(1'b0, s, p, slp);
    endtask

    initial begin : monitor
        forever begin
            @(posedge clk);
            #1;
            if (exp_q.size() != 0) check("scoreboard", dut_obs(), exp_q.pop_front());
        end
    end

    initial begin : driver
        bit s, p, slp;
        model_reset();
        repeat (3) cycle(1'b1, 1'b0, 1'b0, 1'b0);

        // Nominal power-up: PG arrives 10 cycles after AuxEn.
        run(10, 1, 0, 1);
        run(30, 1, 1, 1);

        // S3 cycle from ON.
        run(50, 1, 1, 0);
        run(30, 1, 1, 1);

        // AUX lost together with SLP_S3# falling, then fault clear.
        run(6, 1, 0, 0);
        run(2, 0, 0, 0);

        // Shutdown while in PCHOK_DLY.
        run(24, 1, 1, 1);
        run(3, 0, 1, 1);

        // Asynchronous reset while in SRST_DLY, then restart.
        run(23, 1, 1, 1);
        @(posedge clk);
        #2;
        rst = 1'b1;
        #1;
        model_reset();
        check("async_reset", dut_obs(), model_out());
        repeat (2) cycle(1'b1, 1'b1, 1'b1, 1'b1);
        run(30, 1, 1, 1);

        // AUX power-good timeout, then clear.
        run(3, 0, 0, 1);
        run(T_AUX + 3, 1, 0, 1);
        run(3, 0, 0, 1);

        // Random traffic.
        s   = 1'b1;
        p   = 1'b0;
        slp = 1'b1;
        repeat (4000) begin
            if (s) begin
                if ($urandom_range(299) == 0) s = 1'b0;
            end else if ($urandom_range(9) == 0) s = 1'b1;
            if (p) begin
                if ($urandom_range(499) == 0) p = 1'b0;
            end else if ($urandom_range(29) == 0) p = 1'b1;
            if ($urandom_range(59) == 0) slp = !slp;
            if ($urandom_range(999) == 0) cycle(1'b1, s, p, slp);
            else                          cycle(1'b0, s, p, slp);
        end

        repeat (3) @(posedge clk);
        #2;
        if (exp_q.size() != 0) begin
            vectors++;
            miscompares++;
            $display("FAIL drain: %0d expected responses left unchecked, required 0", exp_q.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
